// File: rtl/lzc_pkg.sv
// lzc_pkg: mode encoding and width/bit-order helpers shared by the leading-zero counter
package lzc_pkg;
  typedef enum logic [1:0] {CLZ = 2'b00, CTZ = 2'b01, CLS = 2'b10, RSVD = 2'b11} lzc_mode_t;
  function automatic int count_width(input int w);
    return $clog2(w) + 1;
  endfunction
  function automatic int index_width(input int g);
    return (g > 1) ? $clog2(g) : 1;
  endfunction
  function automatic logic [63:0] bit_reverse(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction
endpackage

// File: rtl/lzc_group_encoder.sv
// lzc_group_encoder: index of the first non-zero nibble from the MSB (flag bit 0 = MSB nibble)
module lzc_group_encoder
  import lzc_pkg::*;
#(
  parameter int GROUPS = 8,
  localparam int IW = index_width(GROUPS)
) (
  input  logic [GROUPS-1:0] zero,
  output logic [IW-1:0]     idx,
  output logic              all_zero
);
  always_comb begin
    idx = '0;
    for (int g = GROUPS - 1; g >= 0; g--)
      if (!zero[g]) idx = IW'(g);
    all_zero = &zero;
  end
endmodule

// File: rtl/lzc_pipelined_counter.sv
// lzc_pipelined_counter: pipelined CLZ/CTZ/CLS counter with valid/ready handshake.
// Define LZC_NORMALIZE_EN to add norm_o, the operand shifted by the count.
module lzc_pipelined_counter
  import lzc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic [DATA_WIDTH-1:0]                 operand_i,
  input  logic [1:0]                            mode_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [count_width(DATA_WIDTH)-1:0]    count_o,
  output logic                                  all_zero_o
`ifdef LZC_NORMALIZE_EN
  ,
  output logic [DATA_WIDTH-1:0]                 norm_o
`endif
);
  localparam int W  = DATA_WIDTH;
  localparam int G  = W / 4;
  localparam int CW = count_width(W);
  localparam int IW = index_width(G);
  typedef struct packed {
    logic [G-1:0][1:0] cnt;
    logic [G-1:0]      zero;
    lzc_mode_t         mode;
`ifdef LZC_NORMALIZE_EN
    logic [W-1:0]      op;
`endif
  } mid_t;
  if (W != 8 && W != 16 && W != 32 && W != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("PIPE_STAGES must be 1 or 2");
  end
  lzc_mode_t         mode;
  logic [W-1:0]      word;
  logic [G-1:0][1:0] nib_cnt;
  logic [G-1:0]      nib_zero;
  mid_t              front, mid;
  logic              mid_valid, ld, az;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     raw, cnt;
  assign mode = lzc_mode_t'(mode_i);
  // CLS turns "bits equal to the MSB" into leading zeros of adjacent-bit differences
  assign word = mode == CTZ ? W'(bit_reverse(64'(operand_i) << (64 - W)))
              : mode == CLS ? {1'b0, operand_i[W-1:1] ^ operand_i[W-2:0]} : operand_i;
  for (genvar g = 0; g < G; g++) begin : g_nib
    logic [3:0] n;
    assign n           = word[W-1-4*g -: 4];
    assign nib_zero[g] = ~|n;
    assign nib_cnt[g]  = n[3] ? 2'd0 : n[2] ? 2'd1 : n[1] ? 2'd2 : 2'd3;
  end
  always_comb begin
    front      = '0;
    front.cnt  = nib_cnt;
    front.zero = nib_zero;
    front.mode = mode;
`ifdef LZC_NORMALIZE_EN
    front.op   = operand_i;
`endif
  end
  assign ld = !valid_o | ready_i;
  if (PIPE_STAGES == 2) begin : g_two
    mid_t q;
    logic v;
    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
        v <= 1'b0;
        q <= '0;
      end else if (ready_o) begin
        v <= valid_i;
        if (valid_i) q <= front;
      end
    assign ready_o   = !v | ld;
    assign mid       = q;
    assign mid_valid = v;
  end else begin : g_one
    assign ready_o   = ld;
    assign mid       = front;
    assign mid_valid = valid_i;
  end
  lzc_group_encoder #(.GROUPS(G)) u_enc (
    .zero     (mid.zero),
    .idx      (idx),
    .all_zero (az)
  );
  assign raw = az ? CW'(W) : CW'({idx, mid.cnt[idx]});
  assign cnt = mid.mode == CLS ? (raw == '0 ? '0 : raw - CW'(1)) : raw;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      valid_o    <= 1'b0;
      count_o    <= '0;
      all_zero_o <= 1'b0;
    end else begin
      if (ld) valid_o <= mid_valid;
      if (ld && mid_valid) begin
        count_o    <= cnt;
        all_zero_o <= az;
      end
    end
`ifdef LZC_NORMALIZE_EN
  logic [W-1:0] shifted;
  assign shifted = mid.mode == CTZ ? mid.op >> cnt : mid.op << cnt;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) norm_o <= '0;
    else if (ld && mid_valid) norm_o <= shifted;
`endif
endmodule

// File: tb/tb_lzc_pipelined_counter.sv
// tb_lzc_pipelined_counter: 32/64/16-bit counters driven in lockstep, checked by vectors and a reference model
module tb_lzc_pipelined_counter;
  typedef struct packed {
    logic [2:0][6:0]  c;
    logic [2:0]       z;
    logic [2:0][63:0] n;
  } exp_t;
  typedef struct {
    int          w;
    logic [1:0]  m;
    logic [63:0] op;
    int          c;
    bit          z;
    bit          chk_n;
    logic [63:0] n;
  } vec_t;
  logic             clk, rst_n, valid, rdy_in;
  logic [1:0]       mode;
  logic [63:0]      op;
  logic [2:0]       rdy, vo, az;
  logic [5:0]       c32;
  logic [6:0]       c64;
  logic [4:0]       c16;
  logic [2:0][6:0]  cnt, held_c;
  logic [2:0][63:0] nrm;
  logic [2:0]       held_z;
  bit               held_v, saw_block;
  int               n_cmp, n_bad, n_out;
  exp_t             q[$];
  vec_t             tbl[$];
  assign cnt[0] = {1'b0, c32};
  assign cnt[1] = c64;
  assign cnt[2] = {2'b0, c16};
`ifdef LZC_NORMALIZE_EN
  logic [31:0] n32;
  logic [63:0] n64;
  logic [15:0] n16;
  assign nrm[0] = {32'b0, n32};
  assign nrm[1] = n64;
  assign nrm[2] = {48'b0, n16};
`else
  assign nrm = '0;
`endif
  lzc_pipelined_counter #(.DATA_WIDTH(32), .PIPE_STAGES(2)) u_d32 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(rdy[0]), .operand_i(op[31:0]),
    .mode_i(mode), .valid_o(vo[0]), .ready_i(rdy_in), .count_o(c32), .all_zero_o(az[0])
`ifdef LZC_NORMALIZE_EN
    , .norm_o(n32)
`endif
  );
  lzc_pipelined_counter #(.DATA_WIDTH(64), .PIPE_STAGES(2)) u_d64 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(rdy[1]), .operand_i(op),
    .mode_i(mode), .valid_o(vo[1]), .ready_i(rdy_in), .count_o(c64), .all_zero_o(az[1])
`ifdef LZC_NORMALIZE_EN
    , .norm_o(n64)
`endif
  );
  lzc_pipelined_counter #(.DATA_WIDTH(16), .PIPE_STAGES(2)) u_d16 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(rdy[2]), .operand_i(op[15:0]),
    .mode_i(mode), .valid_o(vo[2]), .ready_i(rdy_in), .count_o(c16), .all_zero_o(az[2])
`ifdef LZC_NORMALIZE_EN
    , .norm_o(n16)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int wid(input int i);
    return i == 0 ? 32 : i == 1 ? 64 : 16;
  endfunction
  function automatic int sel(input int w);
    return w == 32 ? 0 : w == 64 ? 1 : 2;
  endfunction
  // Reference: walk the bits named by the mode, one at a time
  function automatic void model(input int w, input logic [1:0] m, input logic [63:0] x,
                                output int c, output bit z, output logic [63:0] n);
    logic [63:0] mask, v;
    mask = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    v = x & mask;
    c = 0;
    if (m == 2'b01) begin
      while (c < w && !v[c]) c++;
      z = (v == 0);
      n = v >> c;
    end else if (m == 2'b10) begin
      while (c < w - 1 && v[w-2-c] == v[w-1]) c++;
      z = (v == 0) || (v == mask);
      n = (v << c) & mask;
    end else begin
      while (c < w && !v[w-1-c]) c++;
      z = (v == 0);
      n = (v << c) & mask;
    end
  endfunction
  function automatic logic [63:0] rnd_op();
    logic [63:0] r;
    int k;
    r = {$urandom, $urandom};
    k = $urandom_range(0, 63);
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return r >> k;
      3: return ~(r >> k);
      4: return r << k;
      default: return r;
    endcase
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] m, input logic [63:0] o);
    exp_t e;
    int ci;
    bit zi, ok;
    logic [63:0] ni;
    valid = 1'b1;
    mode = m;
    op = o;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (rdy[0]) begin
        for (int i = 0; i < 3; i++) begin
          model(wid(i), m, o, ci, zi, ni);
          e.c[i] = 7'(ci);
          e.z[i] = zi;
          e.n[i] = ni;
        end
        q.push_back(e);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    chk("send_accept", 64'(ok), 1);
  endtask
  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(q.size()), 0);
  endtask
  // Scoreboard and stall-stability monitor, sampled on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) held_v = 0;
      else begin
        if (held_v) begin
          chk("stall_valid", 64'(vo), 3'b111);
          chk("stall_count", 64'(cnt), 64'(held_c));
          chk("stall_all_zero", 64'(az), 64'(held_z));
        end
        held_v = vo[0] && !rdy_in;
        held_c = cnt;
        held_z = az;
        if (valid && !rdy[0]) saw_block = 1;
        if (vo[0] && rdy_in) begin
          n_out++;
          if (q.size() == 0) chk("unexpected_result", 64'(vo), 0);
          else begin
            e = q.pop_front();
            for (int i = 0; i < 3; i++) begin
              chk($sformatf("sb_w%0d_count", wid(i)), 64'(cnt[i]), 64'(e.c[i]));
              chk($sformatf("sb_w%0d_all_zero", wid(i)), 64'(az[i]), 64'(e.z[i]));
`ifdef LZC_NORMALIZE_EN
              chk($sformatf("sb_w%0d_norm", wid(i)), nrm[i], e.n[i]);
`endif
            end
          end
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int s, n0;
    bit done;
    n_cmp = 0; n_bad = 0; n_out = 0; held_v = 0; saw_block = 0;
    rst_n = 1'b0; valid = 1'b0; rdy_in = 1'b1; mode = 2'b00; op = '0;
    tbl.push_back('{32, 2'b00, 64'h0000_0000_0001_0000, 15, 0, 0, 0});
    tbl.push_back('{64, 2'b00, 64'h0, 64, 1, 0, 0});
    tbl.push_back('{64, 2'b01, 64'h8000_0000_0000_0000, 63, 0, 0, 0});
    tbl.push_back('{16, 2'b10, 64'hFFF0, 11, 0, 0, 0});
    tbl.push_back('{16, 2'b10, 64'h0000, 15, 1, 0, 0});
    tbl.push_back('{16, 2'b10, 64'h4000, 0, 0, 0, 0});
    tbl.push_back('{32, 2'b01, 64'h1, 0, 0, 0, 0});
    tbl.push_back('{32, 2'b11, 64'h8000_0000, 0, 0, 0, 0});
    tbl.push_back('{32, 2'b10, 64'hFFFF_FFFF, 31, 1, 0, 0});
    tbl.push_back('{32, 2'b10, 64'h0000_FFFF, 15, 0, 0, 0});
    tbl.push_back('{16, 2'b01, 64'h0, 16, 1, 0, 0});
    tbl.push_back('{64, 2'b00, 64'h1, 63, 0, 0, 0});
    tbl.push_back('{32, 2'b00, 64'h0000_0C00, 20, 0, 1, 64'hC000_0000});
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(vo), 0);
    chk("reset_count", 64'(cnt), 0);
    chk("reset_all_zero", 64'(az), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(rdy), 3'b111);
    foreach (tbl[k]) begin
      s = sel(tbl[k].w);
      send(tbl[k].m, tbl[k].op);
      chk($sformatf("vec%0d_early", k), 64'(vo[s]), 0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", k), 64'(vo[s]), 1);
      chk($sformatf("vec%0d_count", k), 64'(cnt[s]), 64'(tbl[k].c));
      chk($sformatf("vec%0d_all_zero", k), 64'(az[s]), 64'(tbl[k].z));
`ifdef LZC_NORMALIZE_EN
      if (tbl[k].chk_n) chk($sformatf("vec%0d_norm", k), nrm[s], tbl[k].n);
`endif
      @(posedge clk);
      #1;
    end
    drain();
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(2'($urandom_range(0, 3)), rnd_op());
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          rdy_in = ($urandom_range(0, 3) != 0);
        end
        rdy_in = 1'b1;
      end
    join
    drain();
    n0 = n_out;
    saw_block = 0;
    fork
      for (int i = 0; i < 10; i++) send(2'($urandom_range(0, 3)), rnd_op());
      begin
        repeat (3) @(posedge clk);
        #1;
        rdy_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rdy_in = 1'b1;
      end
    join
    drain();
    chk("stall_ready_dropped", 64'(saw_block), 1);
    chk("stall_result_count", 64'(n_out - n0), 10);
    rdy_in = 1'b0;
    send(2'b00, 64'h10);
    send(2'b00, 64'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(vo), 0);
    chk("midrst_count", 64'(cnt), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_in = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", 64'(rdy), 3'b111);
    n0 = n_out;
    send(2'b00, 64'h100);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(vo), 3'b111);
    chk("post_rst_count32", 64'(cnt[0]), 23);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_results", 64'(n_out - n0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lzc_pipelined_counter.md
Name: lzc_pipelined_counter

Overview:
- Parametrised, pipelined successor of the 24/32-bit combinational leading-zero counter.
- Counts leading zeros, trailing zeros or redundant sign bits of any power-of-two width from 8 to 64.
- Has a valid/ready handshake and returns a full-range count, so an all-zero word reports DATA_WIDTH.
- Sits in front of the FP normaliser and the bit-manipulation ALU unit.

Parameters:
- DATA_WIDTH, 32, operand width; power of two, 8..64; any other value is a compile-time error.
- PIPE_STAGES, 2, register stages: 1 registers the final count only; 2 adds a register after the nibble layer.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- valid_i  in  1  input word valid.
- ready_o  out  1  block can accept a word this cycle.
- operand_i  in  DATA_WIDTH  word to count.
- mode_i  in  2  00 CLZ, 01 CTZ, 10 CLS (leading bits equal to MSB, excluding MSB), 11 reserved (treated as CLZ).
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- count_o  out  $clog2(DATA_WIDTH)+1  count, range 0..DATA_WIDTH.
- all_zero_o  out  1  word after mode pre-processing was all zero.

Behaviour:
- Reset: valid_o=0, count_o=0, all_zero_o=0 and all stage valid bits 0; ready_o=1 once reset is released. Reset mid-operation discards every in-flight word.
- Pre-processing (combinational, input side):
  - CLZ: word used unchanged.
  - CTZ: word bit-reversed.
  - CLS: word = operand_i XOR (operand_i >> 1), with the MSB forced 0. The CLZ of this word minus 1 gives the CLS result, saturated at 0; an all-sign word gives DATA_WIDTH-1.
- Counting:
  - Per-nibble 2-bit zero counts and all-zero flags.
  - A priority encoder over the all-zero flags picks the first non-zero nibble from the MSB.
  - count = 4*nibble_index + nibble_count.
  - An all-zero word forces count=DATA_WIDTH and all_zero_o=1.
- Pipeline:
  - Each stage holds a valid bit.
  - A stage loads when it is empty or its downstream is advancing.
  - ready_o = !stage0_valid | stage0_advancing, i.e. full throughput with no bubble under continuous ready_i.
- Latency: PIPE_STAGES cycles from the accepting edge (valid_i & ready_o) to valid_o.
- Backpressure: while valid_o=1 and ready_i=0, count_o, all_zero_o and valid_o hold stable. Upstream fills remaining stages, then ready_o drops.
- Simultaneous accept and drain on a full pipe: accepted in the same cycle, no loss.
- Words never reorder or duplicate; each accepted word produces exactly one result.
- mode_i is sampled with operand_i and travels with the word.

Optional Feature:
- Macro LZC_NORMALIZE_EN.
- Defined:
  - Adds output norm_o [DATA_WIDTH-1:0], equal to operand_i << count, pipelined alongside count_o.
  - For CTZ it is operand_i >> count instead.
  - For CLS the shift is by the CLS result.
  - An all-zero word gives norm_o=0.
  - Adds one extra barrel-shift register; latency stays PIPE_STAGES.
- Undefined: no norm_o port and no shifter logic.

Decomposition:
- Package lzc_pkg holds:
  - typedef lzc_mode_t (enum CLZ, CTZ, CLS, RSVD).
  - A function returning the count width from DATA_WIDTH.
  - A bit-reverse function.
- One sub-module, lzc_group_encoder: combinational, parametrised by group count. It takes the nibble all-zero flags and outputs the leading non-zero nibble index and an all-zero flag. It is instantiated once.

Test Plan:
- DATA_WIDTH=32, CLZ, operand 0x0001_0000, ready_i=1 -> count_o=15 after 2 cycles, all_zero_o=0.
- DATA_WIDTH=64, CLZ, operand 0 -> count_o=64, all_zero_o=1; CTZ with 0x8000_0000_0000_0000 -> count_o=63.
- DATA_WIDTH=16, CLS:
  - operand 0xFFF0 -> count_o=11.
  - operand 0x0000 -> count_o=15.
  - operand 0x4000 -> count_o=0.
- Back-to-back stream of 10 words, ready_i held 0 for cycles 3..6:
  - ready_o drops once all PIPE_STAGES stages are full.
  - Outputs hold stable while stalled.
  - All 10 results arrive in order, none lost or duplicated.
- Assert rst_n_i low while 2 words are in flight -> valid_o=0 immediately; after release the next word gives the correct count and no stale result appears.
- With LZC_NORMALIZE_EN, DATA_WIDTH=32, CLZ, operand 0x0000_0C00 -> count_o=20, norm_o=0xC000_0000.
